// File: rtl/isa_pkg.sv
// Shared pico-MIPS ISA definitions: opcodes, field widths, loader FSM states
// and the canonical instruction encoder.
package isa_pkg;

    localparam int OPCODE_WIDTH       = 6;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_IMM_WIDTH      = 8;
    localparam int DEF_INSTR_WIDTH    = OPCODE_WIDTH + 2 * DEF_REG_ADDR_WIDTH + DEF_IMM_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_MLT  = 6'h07;
    localparam logic [OPCODE_WIDTH-1:0] OP_MLTI = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 6'h0A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Which operand fields survive canonicalisation; the rest are forced to 0.
    typedef struct packed {
        logic rd;
        logic rs;
        logic imm;
    } keep_t;

    function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_BEQ,
            OP_JMP, OP_MLT, OP_MLTI, OP_LD, OP_ST: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic keep_t field_keep(input logic [OPCODE_WIDTH-1:0] op);
        keep_t k;
        k = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MLT: begin
                k.rd = 1'b1;
                k.rs = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MLTI, OP_BEQ: begin
                k.rd  = 1'b1;
                k.rs  = 1'b1;
                k.imm = 1'b1;
            end
            OP_JMP:  k.imm = 1'b1;
            OP_LD:   k.rd  = 1'b1;
            OP_ST:   k.rs  = 1'b1;
            default: k = '0;
        endcase
        return k;
    endfunction

    function automatic logic [DEF_INSTR_WIDTH-1:0] encode_instr(
        input logic [OPCODE_WIDTH-1:0]       op,
        input logic [DEF_REG_ADDR_WIDTH-1:0] rd,
        input logic [DEF_REG_ADDR_WIDTH-1:0] rs,
        input logic [DEF_IMM_WIDTH-1:0]      imm
    );
        keep_t k;
        k = field_keep(op);
        return {op,
                rd  & {DEF_REG_ADDR_WIDTH{k.rd}},
                rs  & {DEF_REG_ADDR_WIDTH{k.rs}},
                imm & {DEF_IMM_WIDTH{k.imm}}};
    endfunction

endpackage

// File: rtl/prog_loader_encoder_if.sv
// Host-side instruction stream plus program-RAM write port and loader status.
interface prog_loader_encoder_if
    import isa_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 8
);
    localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH;

    // A beat transfers on a rising edge where in_valid and in_ready are both
    // high; the host holds the fields stable while in_valid waits for in_ready.
    logic                      start;
    logic                      in_valid;
    logic                      in_ready;
    logic [OPCODE_WIDTH-1:0]   in_opcode;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic [REG_ADDR_WIDTH-1:0] in_rs;
    logic [IMM_WIDTH-1:0]      in_imm;
    logic                      in_last;

    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [INSTR_WIDTH-1:0]    mem_wdata;

    logic                      cpu_hold;
    logic                      done;
    logic                      error;
    logic [ADDR_WIDTH:0]       count;
    state_t                    dbg_state;

    modport master (
        output start, in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, count, dbg_state
    );

    modport slave (
        input  start, in_valid, in_opcode, in_rd, in_rs, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, count, dbg_state
    );

endinterface

// File: rtl/instr_packer.sv
// Combinational canonicalise-and-pack of one instruction's fields into a word,
// opcode in the MSBs, plus an opcode legality flag.
module instr_packer
    import isa_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 8,
    localparam int INSTR_WIDTH   = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0]   i_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [IMM_WIDTH-1:0]      i_imm,
    output logic [INSTR_WIDTH-1:0]    o_word,
    output logic                      o_legal
);
    keep_t w_keep;

    assign w_keep  = field_keep(i_opcode);
    assign o_legal = is_legal(i_opcode);

    // NOP is opcode 0 with no kept fields, so it packs to an all-zero word.
    assign o_word = {i_opcode,
                     i_rd  & {REG_ADDR_WIDTH{w_keep.rd}},
                     i_rs  & {REG_ADDR_WIDTH{w_keep.rs}},
                     i_imm & {IMM_WIDTH{w_keep.imm}}};

endmodule

// File: rtl/prog_loader_encoder.sv
// Boot-time program loader: accepts instruction fields, writes canonical words
// to program RAM sequentially from address 0, and holds the CPU until done.
module prog_loader_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_loader_encoder_if.slave bus
);
    localparam int INSTR_WIDTH = OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [INSTR_WIDTH-1:0] r_mem_wdata;
    logic                   r_cpu_hold;
    logic                   r_done;
    logic                   r_error;
    logic [ADDR_WIDTH:0]    r_count;

    logic [INSTR_WIDTH-1:0] w_word;
    logic                   w_legal;
    logic                   w_accept;
    logic                   w_full;

    instr_packer #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .IMM_WIDTH      (IMM_WIDTH)
    ) u_packer (
        .i_opcode (bus.in_opcode),
        .i_rd     (bus.in_rd),
        .i_rs     (bus.in_rs),
        .i_imm    (bus.in_imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // r_in_ready is high exactly while the FSM sits in LOAD.
    assign w_accept = bus.in_valid && r_in_ready;
    // count == depth: the write address counter has wrapped past the last word.
    assign w_full   = r_count[ADDR_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (bus.start) begin
                // Start wins over a same-cycle beat; a write issued last
                // cycle is already on the RAM port and completes untouched.
                r_state    <= S_LOAD;
                r_in_ready <= 1'b1;
                r_cpu_hold <= 1'b1;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_count    <= '0;
            end else if (r_state == S_LOAD && w_accept) begin
                if (!w_legal || w_full) begin
                    r_state    <= S_ERR;
                    r_in_ready <= 1'b0;
                    r_error    <= 1'b1;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_count[ADDR_WIDTH-1:0];
                    r_mem_wdata <= w_word;
                    r_count     <= r_count + COUNT_ONE;
                    if (bus.in_last) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.count     = r_count;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader_encoder.sv
// Bench for prog_loader_encoder: directed vector table, hand-written corner
// sequences, and randomized sessions scored against a field-rule model.
module tb_prog_loader_encoder;
    import isa_pkg::*;

    localparam int DEPTH = 64;
    localparam int EW    = 32 + 6 + 24;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    logic [EW-1:0] exp_q[$];

    // Bench-level view of the session: 0 idle, 1 loading, 2 done, 3 error.
    int m_state;
    int m_count;

    prog_loader_encoder_if #(.ADDR_WIDTH(6), .REG_ADDR_WIDTH(5), .IMM_WIDTH(8)) bus ();
    prog_loader_encoder_if #(.ADDR_WIDTH(2), .REG_ADDR_WIDTH(5), .IMM_WIDTH(8)) bus2 ();

    prog_loader_encoder #(.ADDR_WIDTH(6), .REG_ADDR_WIDTH(5), .IMM_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    prog_loader_encoder #(.ADDR_WIDTH(2), .REG_ADDR_WIDTH(5), .IMM_WIDTH(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each write on the main RAM port must match the oldest
    // expected {cycle, addr, word} entry.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%06h at cycle %0d",
                         bus.mem_addr, bus.mem_wdata, cyc);
            end else begin
                chk("mem_write", {32'(cyc), bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_legal(input int op);
        return op >= 0 && op <= 10;
    endfunction

    function automatic logic [23:0] model_word(input int op, input int rd, input int rs, input int imm);
        int w;
        case (op)
            0:          return 24'd0;
            1, 2, 7:    imm = 0;
            6:          begin rd = 0; rs = 0; end
            9:          begin rs = 0; imm = 0; end
            10:         begin rd = 0; imm = 0; end
            default:    ;
        endcase
        w = op * 262144 + rd * 8192 + rs * 256 + imm;
        return w[23:0];
    endfunction

    task automatic model_start();
        m_state = 1;
        m_count = 0;
    endtask

    task automatic model_beat(input int op, input int rd, input int rs, input int imm,
                              input bit last, input int exp_cyc);
        if (m_state != 1) return;
        if (!model_legal(op) || m_count == DEPTH) begin
            m_state = 3;
        end else begin
            exp_q.push_back({32'(exp_cyc), 6'(m_count), model_word(op, rd, rs, imm)});
            m_count++;
            if (last) m_state = 2;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"},     bus.done,     m_state == 2);
        chk({tag, "_error"},    bus.error,    m_state == 3);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, m_state != 2);
        chk({tag, "_in_ready"}, bus.in_ready, m_state == 1);
        chk({tag, "_count"},    bus.count,    m_count);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        model_start();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int op, input int rd, input int rs, input int imm, input bit last);
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'(op);
        bus.in_rd     = 5'(rd);
        bus.in_rs     = 5'(rs);
        bus.in_imm    = 8'(imm);
        bus.in_last   = last;
        model_beat(op, rd, rs, imm, last, cyc + 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    function automatic int rand_op();
        int r;
        r = $urandom_range(0, 15);
        if (r <= 10) return r;
        if (r == 15) return $urandom_range(11, 63);
        return $urandom_range(0, 10);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [7:0]  imm;
        logic [23:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        checks  = 0;
        errors  = 0;
        m_state = 0;
        m_count = 0;

        vecs[0]  = '{6'h01, 5'd3,  5'd5,  8'h7F, 24'h046500, 1'b0};
        vecs[1]  = '{6'h02, 5'd1,  5'd2,  8'hFF, 24'h082200, 1'b0};
        vecs[2]  = '{6'h03, 5'd1,  5'd2,  8'h10, 24'h0C2210, 1'b0};
        vecs[3]  = '{6'h04, 5'd9,  5'd10, 8'h80, 24'h112A80, 1'b0};
        vecs[4]  = '{6'h05, 5'd0,  5'd1,  8'hFE, 24'h1401FE, 1'b0};
        vecs[5]  = '{6'h06, 5'd7,  5'd7,  8'h03, 24'h180003, 1'b0};
        vecs[6]  = '{6'h07, 5'd31, 5'd31, 8'hAA, 24'h1FFF00, 1'b0};
        vecs[7]  = '{6'h08, 5'd2,  5'd3,  8'h55, 24'h204355, 1'b0};
        vecs[8]  = '{6'h09, 5'd4,  5'd6,  8'h12, 24'h248000, 1'b0};
        vecs[9]  = '{6'h0A, 5'd4,  5'd2,  8'h33, 24'h280200, 1'b0};
        vecs[10] = '{6'h00, 5'd5,  5'd5,  8'h05, 24'h000000, 1'b0};
        vecs[11] = '{6'h3F, 5'd1,  5'd1,  8'h01, 24'h000000, 1'b1};
        vecs[12] = '{6'h0B, 5'd2,  5'd3,  8'h04, 24'h000000, 1'b1};
        vecs[13] = '{6'h20, 5'd0,  5'd0,  8'h00, 24'h000000, 1'b1};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_opcode  = '0;
        bus.in_rd      = '0;
        bus.in_rs      = '0;
        bus.in_imm     = '0;
        bus.in_last    = 1'b0;
        bus2.start     = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_opcode = '0;
        bus2.in_rd     = '0;
        bus2.in_rs     = '0;
        bus2.in_imm    = '0;
        bus2.in_last   = 1'b0;

        // Reset values
        #3;
        chk("rst_in_ready",  bus.in_ready,  1'b0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  6'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 24'd0);
        chk("rst_cpu_hold",  bus.cpu_hold,  1'b1);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_error",     bus.error,     1'b0);
        chk("rst_count",     bus.count,     7'd0);
        chk("rst_state",     bus.dbg_state, S_IDLE);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_status("idle");

        // Single-beat sessions from the table; each start must clear status.
        for (int i = 0; i < 14; i++) begin
            do_start();
            chk("tbl_start_error",    bus.error,    1'b0);
            chk("tbl_start_done",     bus.done,     1'b0);
            chk("tbl_start_in_ready", bus.in_ready, 1'b1);
            chk("tbl_start_count",    bus.count,    7'd0);
            bus.in_valid  = 1'b1;
            bus.in_opcode = vecs[i].op;
            bus.in_rd     = vecs[i].rd;
            bus.in_rs     = vecs[i].rs;
            bus.in_imm    = vecs[i].imm;
            bus.in_last   = 1'b1;
            if (!vecs[i].err) exp_q.push_back({32'(cyc + 1), 6'd0, vecs[i].word});
            tick();
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            chk("tbl_done",     bus.done,     !vecs[i].err);
            chk("tbl_error",    bus.error,    vecs[i].err);
            chk("tbl_cpu_hold", bus.cpu_hold, vecs[i].err);
            chk("tbl_in_ready", bus.in_ready, 1'b0);
            chk("tbl_count",    bus.count,    vecs[i].err ? 7'd0 : 7'd1);
            chk("tbl_state",    bus.dbg_state, vecs[i].err ? S_ERR : S_DONE);
        end
        tick();
        m_state = 2;
        m_count = 1;

        // Four back-to-back beats
        do_start();
        send(3, 1, 2, 8'h10, 1'b0);
        send(5, 0, 1, 8'hFE, 1'b0);
        send(6, 7, 7, 8'h03, 1'b0);
        send(10, 4, 2, 8'h55, 1'b1);
        check_status("b2b");
        tick();
        chk("b2b_we_after_done", bus.mem_we, 1'b0);

        // Reset mid-burst aborts immediately
        do_start();
        send(1, 1, 1, 1, 1'b0);
        send(2, 2, 2, 2, 1'b0);
        @(negedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'(OP_ADD);
        reset         = 1'b1;
        #1;
        m_state = 0;
        m_count = 0;
        chk("rstmid_mem_we", bus.mem_we, 1'b0);
        check_status("rstmid");
        tick();
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_status("rstmid_idle");
        do_start();
        send(9, 5, 6, 7, 1'b1);
        check_status("rstmid_restart");

        // Start during LOAD, same cycle as a beat
        do_start();
        send(1, 1, 2, 3, 1'b0);
        send(2, 4, 5, 6, 1'b0);
        send(7, 7, 8, 9, 1'b0);
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'(OP_ADDI);
        bus.in_rd     = 5'd11;
        bus.in_rs     = 5'd12;
        bus.in_imm    = 8'h44;
        model_start();
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check_status("restart");
        send(4, 3, 3, 8'h21, 1'b1);
        check_status("restart_done");

        // Fill the whole 64-word memory, then overflow
        do_start();
        for (int i = 0; i < DEPTH; i++)
            send($urandom_range(1, 10), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 255), 1'b0);
        check_status("full");
        send(1, 1, 1, 1, 1'b1);
        check_status("overflow");
        tick();

        // Randomized sessions with gaps between beats
        for (int s = 0; s < 25; s++) begin
            int len;
            do_start();
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(rand_op(), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 255), k == len - 1);
            end
            tick();
            check_status("rnd");
        end

        // Small memory (4 words): last address without in_last, then overflow
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid  = 1'b1;
            bus2.in_opcode = 6'(OP_ADDI);
            bus2.in_rd     = 5'(i + 1);
            bus2.in_rs     = 5'(i + 2);
            bus2.in_imm    = 8'(i * 16 + 1);
            bus2.in_last   = 1'b0;
            tick();
            chk("small_we",   bus2.mem_we,    1'b1);
            chk("small_addr", bus2.mem_addr,  i);
            chk("small_data", bus2.mem_wdata, model_word(3, i + 1, i + 2, i * 16 + 1));
        end
        chk("small_last_in_ready", bus2.in_ready, 1'b1);
        chk("small_last_error",    bus2.error,    1'b0);
        chk("small_last_count",    bus2.count,    3'd4);
        tick();
        chk("small_ovf_we",       bus2.mem_we,   1'b0);
        chk("small_ovf_error",    bus2.error,    1'b1);
        chk("small_ovf_count",    bus2.count,    3'd4);
        chk("small_ovf_in_ready", bus2.in_ready, 1'b0);
        chk("small_ovf_cpu_hold", bus2.cpu_hold, 1'b1);
        bus2.in_valid = 1'b0;
        tick();
        chk("small_err_we", bus2.mem_we, 1'b0);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("small_restart_error",    bus2.error,    1'b0);
        chk("small_restart_in_ready", bus2.in_ready, 1'b1);
        chk("small_restart_count",    bus2.count,    3'd0);

        repeat (3) tick();
        chk("pending_writes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
